// File: rtl/arb_pkg.sv
// Shared types and limits for the round-robin burst arbiter.
package arb_pkg;

   localparam int unsigned ARB_MAX_REQ = 16;

   typedef enum logic [0:0] {
      ARB_IDLE    = 1'b0,
      ARB_GRANTED = 1'b1
   } arb_state_t;

endpackage : arb_pkg

// File: rtl/oh_to_idx.sv
// One-hot to binary index encoder; all-zero input encodes to 0.
module oh_to_idx #(
   parameter int unsigned OH_WIDTH  = 4,
   parameter int unsigned IDX_WIDTH = (OH_WIDTH > 1) ? $clog2(OH_WIDTH) : 1
) (
   input  logic [OH_WIDTH-1:0]  oh_i,
   output logic [IDX_WIDTH-1:0] idx_o
);

   // OR together the indices of set bits; exact for a one-hot input.
   always_comb begin
      idx_o = '0;
      for (int unsigned i = 0; i < OH_WIDTH; i++) begin
         if (oh_i[i]) idx_o = idx_o | IDX_WIDTH'(i);
      end
   end

endmodule : oh_to_idx

// File: rtl/rr_priority_pick.sv
// Rotate-priority-rotate picker: lowest set request at or above ptr, wrapping.
module rr_priority_pick #(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned IDX_WIDTH = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0]   request,
   input  logic [IDX_WIDTH-1:0] ptr,
   output logic [NUM_REQ-1:0]   winner_oh
);

   logic [2*NUM_REQ-1:0] dbl_req;
   logic [2*NUM_REQ-1:0] dbl_win;
   logic [NUM_REQ-1:0]   rot_req;
   logic [NUM_REQ-1:0]   rot_win;

   // Rotate so ptr sits at bit 0, isolate lowest set bit, rotate back.
   always_comb begin
      dbl_req   = {request, request} >> ptr;
      rot_req   = dbl_req[NUM_REQ-1:0];
      rot_win   = rot_req & (~rot_req + NUM_REQ'(1));
      dbl_win   = {rot_win, rot_win} << ptr;
      winner_oh = dbl_win[2*NUM_REQ-1:NUM_REQ];
   end

endmodule : rr_priority_pick

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter with registered grant held until accepted.
// Optional burst locking via `RR_ARB_BURST_LOCK_EN: grant held until the
// beat with req_last=1 is accepted; otherwise every accept releases.
module rr_burst_arbiter
   import arb_pkg::*;
#(
   parameter int unsigned NUM_REQ   = 4,
   parameter int unsigned IDX_WIDTH = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_REQ-1:0]   request,
   input  logic                 req_last,
   input  logic                 res_ready,
   output logic                 grant_valid,
   output logic [NUM_REQ-1:0]   grant_oh,
   output logic [IDX_WIDTH-1:0] grant_idx
);

   if (NUM_REQ < 2 || NUM_REQ > ARB_MAX_REQ) begin : g_bad_num_req
      $error("rr_burst_arbiter: NUM_REQ out of range");
   end

   arb_state_t           state_q;
   logic [IDX_WIDTH-1:0] ptr_q;
   logic                 accept_c;
   logic                 release_c;
   logic [IDX_WIDTH-1:0] rel_ptr_c;
   logic [IDX_WIDTH-1:0] search_ptr_c;
   logic [NUM_REQ-1:0]   winner_c;

`ifndef RR_ARB_BURST_LOCK_EN
   logic unused_c;
   assign unused_c = req_last;
`endif

   // Accept/release decode; on release the search starts just past the owner
   // so the releasing requester is considered last.
   always_comb begin
      accept_c = grant_valid && res_ready;
`ifdef RR_ARB_BURST_LOCK_EN
      release_c = accept_c && req_last;
`else
      release_c = accept_c;
`endif
      rel_ptr_c    = (grant_idx == IDX_WIDTH'(NUM_REQ - 1)) ? '0
                                                            : IDX_WIDTH'(grant_idx + 1'b1);
      search_ptr_c = release_c ? rel_ptr_c : ptr_q;
   end

   rr_priority_pick #(
      .NUM_REQ   (NUM_REQ),
      .IDX_WIDTH (IDX_WIDTH)
   ) u_pick (
      .request   (request),
      .ptr       (search_ptr_c),
      .winner_oh (winner_c)
   );

   // Grant FSM: load on idle request, reload or go idle on release, else hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ARB_IDLE;
         grant_valid <= 1'b0;
         grant_oh    <= '0;
         ptr_q       <= '0;
      end else begin
         if (release_c) ptr_q <= rel_ptr_c;
         case (state_q)
            ARB_IDLE: begin
               if (|request) begin
                  state_q     <= ARB_GRANTED;
                  grant_valid <= 1'b1;
                  grant_oh    <= winner_c;
               end
            end
            ARB_GRANTED: begin
               if (release_c) begin
                  if (|request) begin
                     grant_oh <= winner_c;
                  end else begin
                     state_q     <= ARB_IDLE;
                     grant_valid <= 1'b0;
                     grant_oh    <= '0;
                  end
               end
            end
            default: begin
               state_q     <= ARB_IDLE;
               grant_valid <= 1'b0;
               grant_oh    <= '0;
            end
         endcase
      end
   end

   oh_to_idx #(
      .OH_WIDTH  (NUM_REQ),
      .IDX_WIDTH (IDX_WIDTH)
   ) u_enc (
      .oh_i  (grant_oh),
      .idx_o (grant_idx)
   );

endmodule : rr_burst_arbiter

// File: tb/tb_rr_burst_arbiter.sv
// Directed bench for rr_burst_arbiter (NUM_REQ=4).
module tb_rr_burst_arbiter;

   logic       clk;
   logic       rst_n;
   logic [3:0] request;
   logic       req_last;
   logic       res_ready;
   logic       grant_valid;
   logic [3:0] grant_oh;
   logic [1:0] grant_idx;

   int n_cmp;
   int n_err;

   typedef struct {
      logic [3:0] req;
      logic       rdy;
      logic       last;
      logic       v;
      logic [3:0] oh;
      logic [1:0] idx;
   } vec_t;

   vec_t vecs[14];

   rr_burst_arbiter #(.NUM_REQ(4), .IDX_WIDTH(2)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .request     (request),
      .req_last    (req_last),
      .res_ready   (res_ready),
      .grant_valid (grant_valid),
      .grant_oh    (grant_oh),
      .grant_idx   (grant_idx)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic vec_t mk(logic [3:0] req, logic rdy, logic last,
                               logic v, logic [3:0] oh, logic [1:0] idx);
      vec_t r;
      r.req = req; r.rdy = rdy; r.last = last;
      r.v = v; r.oh = oh; r.idx = idx;
      return r;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(logic [3:0] req, logic rdy, logic last);
      request   = req;
      res_ready = rdy;
      req_last  = last;
   endtask

   task automatic check(string name, logic v, logic [3:0] oh, logic [1:0] idx);
      n_cmp++;
      if (grant_valid !== v || grant_oh !== oh || grant_idx !== idx) begin
         n_err++;
         $display("FAIL %s: got valid=%b oh=%b idx=%0d, want valid=%b oh=%b idx=%0d",
                  name, grant_valid, grant_oh, grant_idx, v, oh, idx);
      end
   endtask

   task automatic pulse_reset(string name);
      #3 rst_n = 1'b0;
      drive(4'b0000, 1'b0, 1'b0);
      #1 check(name, 1'b0, 4'b0000, 2'd0);
      #2 rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      n_cmp = 0;
      n_err = 0;
      rst_n = 1'b0;
      drive(4'b0000, 1'b0, 1'b0);

      // Round robin from ptr 0, wrap, pointer effect on simultaneous requests.
      vecs[0]  = mk(4'b1111, 1, 1, 1, 4'b0001, 2'd0);
      vecs[1]  = mk(4'b1111, 1, 1, 1, 4'b0010, 2'd1);
      vecs[2]  = mk(4'b1111, 1, 1, 1, 4'b0100, 2'd2);
      vecs[3]  = mk(4'b1111, 1, 1, 1, 4'b1000, 2'd3);
      vecs[4]  = mk(4'b1111, 1, 1, 1, 4'b0001, 2'd0);
      vecs[5]  = mk(4'b0110, 1, 1, 1, 4'b0010, 2'd1);
      vecs[6]  = mk(4'b0110, 1, 1, 1, 4'b0100, 2'd2);
      vecs[7]  = mk(4'b0110, 1, 1, 1, 4'b0010, 2'd1);
      vecs[8]  = mk(4'b0000, 1, 1, 0, 4'b0000, 2'd0);
      vecs[9]  = mk(4'b0011, 0, 1, 1, 4'b0001, 2'd0);
      vecs[10] = mk(4'b0011, 0, 1, 1, 4'b0001, 2'd0);
      vecs[11] = mk(4'b0011, 1, 1, 1, 4'b0010, 2'd1);
      vecs[12] = mk(4'b0000, 1, 1, 0, 4'b0000, 2'd0);
      vecs[13] = mk(4'b0000, 1, 1, 0, 4'b0000, 2'd0);

      #2 check("reset_state", 1'b0, 4'b0000, 2'd0);
      step();
      step();
      #2 rst_n = 1'b1;

      // Idle with no requests.
      for (int i = 0; i < 5; i++) begin
         step();
         check($sformatf("idle_%0d", i), 1'b0, 4'b0000, 2'd0);
      end

      for (int i = 0; i < 14; i++) begin
         drive(vecs[i].req, vecs[i].rdy, vecs[i].last);
         step();
         check($sformatf("vec_%0d", i), vecs[i].v, vecs[i].oh, vecs[i].idx);
      end

      // Stall: grant on 3 held while not ready, release to idle sets ptr 0.
      drive(4'b1000, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step();
         check($sformatf("stall_%0d", i), 1'b1, 4'b1000, 2'd3);
      end
      drive(4'b0000, 1'b1, 1'b1);
      step();
      check("stall_release", 1'b0, 4'b0000, 2'd0);
      drive(4'b1001, 1'b0, 1'b1);
      step();
      check("ptr_wrapped_to_0", 1'b1, 4'b0001, 2'd0);
      drive(4'b0000, 1'b1, 1'b1);
      step();
      check("release_idle_a", 1'b0, 4'b0000, 2'd0);

      // Async reset while granted idx 2, then ptr back at 0.
      drive(4'b0100, 1'b0, 1'b0);
      step();
      check("grant_idx2", 1'b1, 4'b0100, 2'd2);
      pulse_reset("async_reset_mid_burst");
      drive(4'b0101, 1'b0, 1'b0);
      step();
      check("post_reset_ptr0", 1'b1, 4'b0001, 2'd0);

      // Granted requester drops its request while stalled: grant frozen.
      drive(4'b0010, 1'b1, 1'b1);
      step();
      check("grant_idx1", 1'b1, 4'b0010, 2'd1);
      drive(4'b0000, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step();
         check($sformatf("dropped_hold_%0d", i), 1'b1, 4'b0010, 2'd1);
      end
      drive(4'b0000, 1'b1, 1'b1);
      step();
      check("dropped_release", 1'b0, 4'b0000, 2'd0);

      // Burst of three beats from requester 1 with 2 waiting.
      pulse_reset("reset_before_burst");
      drive(4'b0110, 1'b0, 1'b0);
      step();
      check("burst_grant", 1'b1, 4'b0010, 2'd1);
      drive(4'b0110, 1'b1, 1'b0);
      step();
`ifdef RR_ARB_BURST_LOCK_EN
      check("burst_beat1", 1'b1, 4'b0010, 2'd1);
`else
      check("burst_beat1", 1'b1, 4'b0100, 2'd2);
`endif
      step();
`ifdef RR_ARB_BURST_LOCK_EN
      check("burst_beat2", 1'b1, 4'b0010, 2'd1);
`else
      check("burst_beat2", 1'b1, 4'b0010, 2'd1);
`endif
      drive(4'b0110, 1'b1, 1'b1);
      step();
      check("burst_last", 1'b1, 4'b0100, 2'd2);
      drive(4'b0000, 1'b1, 1'b1);
      step();
      check("burst_end_idle", 1'b0, 4'b0000, 2'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_rr_burst_arbiter
